// File: rtl/fetch.sv
// fetch: MIPS instruction-fetch stage with req/ack imem port, one-entry skid buffer and redirect flush
module fetch #(
  parameter int PWIDTH = 32,
  parameter int IWIDTH = 32,
  parameter logic [PWIDTH-1:0] RESET_PC = '0
) (
  input  logic              f_clk,
  input  logic              f_rst,
  input  logic              f_i_stall,
  input  logic              f_i_change_pc,
  input  logic [PWIDTH-1:0] f_i_alt_pc,
  output logic              f_o_imem_req,
  output logic [PWIDTH-1:0] f_o_imem_addr,
  input  logic              f_i_imem_ack,
  input  logic [IWIDTH-1:0] f_i_imem_instr,
  output logic [IWIDTH-1:0] f_o_instr,
  output logic [PWIDTH-1:0] f_o_pc,
  output logic              f_o_ce
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_STALL} state_t;
  localparam logic [PWIDTH-1:0] ALIGN = ~PWIDTH'(3);
  state_t state_q, state_d;
  logic [PWIDTH-1:0] pc_q, pc_d, pend_q, pend_d, skid_pc_q, skid_pc_d, opc_q, opc_d, alt, pc_inc;
  logic [IWIDTH-1:0] skid_instr_q, skid_instr_d, instr_q, instr_d;
  logic ce_q, ce_d;
  assign alt = f_i_alt_pc & ALIGN;
  assign pc_inc = pc_q + PWIDTH'(4);
  assign f_o_imem_req = state_q == S_REQ || state_q == S_DRAIN;
  assign f_o_imem_addr = pc_q;
  assign f_o_instr = instr_q;
  assign f_o_pc = opc_q;
  assign f_o_ce = ce_q;
  // next-state: redirect beats stall beats ack; an issued request is always drained
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_q;
    skid_pc_d = skid_pc_q;
    skid_instr_d = skid_instr_q;
    opc_d = opc_q;
    instr_d = instr_q;
    ce_d = ce_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        pc_d = f_i_change_pc ? alt : pc_q;
      end
      S_REQ: begin
        if (f_i_change_pc) begin
          ce_d = 1'b0;
          pc_d = f_i_imem_ack ? alt : pc_q;
          pend_d = f_i_imem_ack ? pend_q : alt;
          state_d = f_i_imem_ack ? S_REQ : S_DRAIN;
        end else if (f_i_stall) begin
          if (f_i_imem_ack) begin
            skid_instr_d = f_i_imem_instr;
            skid_pc_d = pc_q;
            pc_d = pc_inc;
            state_d = S_STALL;
          end
        end else if (f_i_imem_ack) begin
          instr_d = f_i_imem_instr;
          opc_d = pc_q;
          ce_d = 1'b1;
          pc_d = pc_inc;
        end else begin
          ce_d = 1'b0;
        end
      end
      S_DRAIN: begin
        ce_d = 1'b0;
        pend_d = f_i_change_pc ? alt : pend_q;
        pc_d = f_i_imem_ack ? (f_i_change_pc ? alt : pend_q) : pc_q;
        state_d = f_i_imem_ack ? S_REQ : S_DRAIN;
      end
      S_STALL: begin
        if (f_i_change_pc) begin
          pc_d = alt;
          ce_d = 1'b0;
          state_d = S_REQ;
        end else if (!f_i_stall) begin
          instr_d = skid_instr_q;
          opc_d = skid_pc_q;
          ce_d = 1'b1;
          state_d = S_REQ;
        end
      end
    endcase
  end
  // state and datapath registers
  always_ff @(posedge f_clk) begin
    if (f_rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC & ALIGN;
      pend_q <= '0;
      skid_pc_q <= '0;
      skid_instr_q <= '0;
      opc_q <= '0;
      instr_q <= '0;
      ce_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      skid_pc_q <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      opc_q <= opc_d;
      instr_q <= instr_d;
      ce_q <= ce_d;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed checks of fetch against a wait-programmable instruction memory
module tb_fetch;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, chg = 1'b0;
  logic [31:0] alt = '0;
  logic req, ack, ce, req2, ce2;
  logic [31:0] addr, instr, pc, idata, addr2, instr2, pc2;
  int wcnt = 0, wait_n = 0, n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h00430820 : a == 32'h4 ? 32'h00A62021 : a == 32'h8 ? 32'h01093822 : 32'hC0DE0000 ^ a;
  endfunction
  assign ack = req & (wcnt >= wait_n);
  assign idata = mem(addr);
  always @(posedge clk) wcnt <= (rst || !req || ack) ? 0 : wcnt + 1;
  fetch dut (.f_clk(clk), .f_rst(rst), .f_i_stall(stall), .f_i_change_pc(chg), .f_i_alt_pc(alt),
    .f_o_imem_req(req), .f_o_imem_addr(addr), .f_i_imem_ack(ack), .f_i_imem_instr(idata),
    .f_o_instr(instr), .f_o_pc(pc), .f_o_ce(ce));
  fetch #(.RESET_PC(32'hFFFFFFFC)) dut_w (.f_clk(clk), .f_rst(rst), .f_i_stall(1'b0), .f_i_change_pc(1'b0),
    .f_i_alt_pc(32'h0), .f_o_imem_req(req2), .f_o_imem_addr(addr2), .f_i_imem_ack(req2),
    .f_i_imem_instr(32'h12345678), .f_o_instr(instr2), .f_o_pc(pc2), .f_o_ce(ce2));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic out_is(input string tag, input logic c, input logic [31:0] p, input logic [31:0] i);
    check({tag, ".ce"}, 64'(ce), 64'(c));
    check({tag, ".pc"}, 64'(pc), 64'(p));
    check({tag, ".instr"}, 64'(instr), 64'(i));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask
  initial begin
    step();
    out_is("rst", 1'b0, 32'h0, 32'h0);
    check("rst.req", 64'(req), 64'd0);
    check("rst.addr", 64'(addr), 64'h0);
    check("rst.w.addr", 64'(addr2), 64'hFFFFFFFC);
    check("rst.w.req", 64'(req2), 64'd0);
    rst = 1'b0;
    step();
    check("e1.req", 64'(req), 64'd1);
    check("e1.addr", 64'(addr), 64'h0);
    check("e1.ce", 64'(ce), 64'd0);
    check("e1.w.addr", 64'(addr2), 64'hFFFFFFFC);
    step();
    out_is("zw0", 1'b1, 32'h0, 32'h00430820);
    check("zw0.addr", 64'(addr), 64'h4);
    check("wrap.addr", 64'(addr2), 64'h0);
    check("wrap.pc", 64'(pc2), 64'hFFFFFFFC);
    check("wrap.ce", 64'(ce2), 64'd1);
    step();
    out_is("zw4", 1'b1, 32'h4, 32'h00A62021);
    step();
    out_is("zw8", 1'b1, 32'h8, 32'h01093822);
    check("zw8.addr", 64'(addr), 64'hC);
    wait_n = 2;
    for (int k = 0; k < 2; k++) begin
      step();
      check("w2.b0", 64'(ce), 64'd0);
      check("w2.addr0", 64'(addr), 64'(32'hC + 4 * k));
      step();
      check("w2.b1", 64'(ce), 64'd0);
      check("w2.addr1", 64'(addr), 64'(32'hC + 4 * k));
      step();
      out_is("w2.v", 1'b1, 32'hC + 4 * k, mem(32'hC + 4 * k));
    end
    wait_n = 0;
    do_reset();
    step();
    out_is("st.pre", 1'b1, 32'h0, 32'h00430820);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      out_is("st.hold", 1'b1, 32'h0, 32'h00430820);
      check("st.req", 64'(req), 64'd0);
    end
    stall = 1'b0;
    step();
    out_is("st.rel", 1'b1, 32'h4, 32'h00A62021);
    check("st.req8", 64'(req), 64'd1);
    check("st.addr8", 64'(addr), 64'h8);
    step();
    out_is("st.next", 1'b1, 32'h8, 32'h01093822);
    do_reset();
    step();
    step();
    chg = 1'b1;
    alt = 32'h103;
    step();
    chg = 1'b0;
    check("rd.ce", 64'(ce), 64'd0);
    check("rd.addr", 64'(addr), 64'h100);
    step();
    out_is("rd.tgt", 1'b1, 32'h100, mem(32'h100));
    wait_n = 2;
    do_reset();
    chg = 1'b1;
    alt = 32'h100;
    step();
    check("dr.addr0", 64'(addr), 64'h0);
    check("dr.req", 64'(req), 64'd1);
    check("dr.ce0", 64'(ce), 64'd0);
    alt = 32'h200;
    stall = 1'b1;
    step();
    chg = 1'b0;
    stall = 1'b0;
    check("dr.addr1", 64'(addr), 64'h0);
    check("dr.ce1", 64'(ce), 64'd0);
    step();
    check("dr.next", 64'(addr), 64'h200);
    check("dr.ce2", 64'(ce), 64'd0);
    step();
    step();
    check("dr.ce3", 64'(ce), 64'd0);
    step();
    out_is("dr.tgt", 1'b1, 32'h200, mem(32'h200));
    do_reset();
    chg = 1'b1;
    alt = 32'h40;
    step();
    chg = 1'b0;
    rst = 1'b1;
    step();
    out_is("rdr", 1'b0, 32'h0, 32'h0);
    check("rdr.req", 64'(req), 64'd0);
    rst = 1'b0;
    step();
    check("rdr.addr", 64'(addr), 64'h0);
    check("rdr.req1", 64'(req), 64'd1);
    wait_n = 0;
    step();
    stall = 1'b1;
    step();
    check("rst.st.req", 64'(req), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall = 1'b0;
    out_is("rst.st", 1'b0, 32'h0, 32'h0);
    check("rst.st.req0", 64'(req), 64'd0);
    step();
    check("rst.st.addr", 64'(addr), 64'h0);
    step();
    out_is("rst.st.v", 1'b1, 32'h0, 32'h00430820);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
